// File: rtl/imm_pack_pkg.sv
// Shared constants for the immediate packer: immsrc codes, legal immediate ranges
// and the output queue depth.
package imm_pack_pkg;

    typedef enum logic [1:0] {
        IMMSRC_I     = 2'b00,
        IMMSRC_S     = 2'b01,
        IMMSRC_B     = 2'b10,
        IMMSRC_SHAMT = 2'b11
    } immsrc_e;

    localparam logic signed [31:0] IMM12_MIN      = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX      = 32'sd2047;
    localparam logic signed [31:0] IMMB_MIN       = -32'sd4096;
    localparam logic signed [31:0] IMMB_MAX       = 32'sd4094;
    localparam logic signed [31:0] SHAMT_MAX      = 32'sd31;
    // I-type immediates in this window decode as the shift form (funct7 = 0100000)
    localparam logic signed [31:0] SHIFT_ALIAS_LO = 32'sd1024;
    localparam logic signed [31:0] SHIFT_ALIAS_HI = 32'sd1055;

    localparam logic [1:0] QUEUE_DEPTH = 2'd2;

endpackage

// File: rtl/imm_pack_enc.sv
// Combinational immediate packer: overlays the immediate fields selected by fmt onto
// the template word and flags immediates the core decoder could not reproduce.
module imm_pack_enc
    import imm_pack_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic signed [31:0] imm_s;

    assign imm_s = signed'(imm);

    // Field placement and range check per immediate format
    always_comb begin
        instr = base;
        err   = 1'b0;
        case (immsrc_e'(fmt))
            IMMSRC_I: begin
                instr[31:20] = imm[11:0];
                err = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX) ||
                      ((imm_s >= SHIFT_ALIAS_LO) && (imm_s <= SHIFT_ALIAS_HI));
            end
            IMMSRC_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                err = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
            end
            IMMSRC_B: begin
                instr[31]    = imm[12];
                instr[7]     = imm[11];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                err = (imm_s < IMMB_MIN) || (imm_s > IMMB_MAX) || imm[0];
            end
            IMMSRC_SHAMT: begin
                instr[24:20] = imm[4:0];
                err = (imm_s < 32'sd0) || (imm_s > SHAMT_MAX);
            end
            default: begin
                instr = base;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_pack_writer.sv
// Packs immediates into instruction templates and streams them through a 2-entry
// queue with sequential word addresses. Optional macro: IMM_PACK_ERR_DROP_EN.
module imm_pack_writer
    import imm_pack_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [31:0]       in_base,
    input  logic [31:0]       in_imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(32'd4);

    logic [31:0]       enc_instr_s;
    logic              enc_err_s;

    logic [31:0]       head_instr_r, head_instr_nxt_s;
    logic [ADDR_W-1:0] head_addr_r,  head_addr_nxt_s;
    logic              head_err_r,   head_err_nxt_s;
    logic [31:0]       tail_instr_r, tail_instr_nxt_s;
    logic [ADDR_W-1:0] tail_addr_r,  tail_addr_nxt_s;
    logic              tail_err_r,   tail_err_nxt_s;
    logic [1:0]        count_r,      count_nxt_s;
    logic [ADDR_W-1:0] addr_r,       addr_nxt_s;
    logic [7:0]        err_cnt_r,    err_cnt_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;

    logic              acc_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] new_addr_s;
    logic              new_err_s;

    imm_pack_enc u_enc (
        .fmt   (in_fmt),
        .base  (in_base),
        .imm   (in_imm),
        .instr (enc_instr_s),
        .err   (enc_err_s)
    );

    // Handshake decode, new-entry fields, queue/counter next state
    always_comb begin
        head_instr_nxt_s = head_instr_r;
        head_addr_nxt_s  = head_addr_r;
        head_err_nxt_s   = head_err_r;
        tail_instr_nxt_s = tail_instr_r;
        tail_addr_nxt_s  = tail_addr_r;
        tail_err_nxt_s   = tail_err_r;
        count_nxt_s      = count_r;
        addr_nxt_s       = addr_r;
        err_cnt_nxt_s    = err_cnt_r;

        acc_s = in_valid && in_ready_r;
        pop_s = out_valid_r && out_ready;
`ifdef IMM_PACK_ERR_DROP_EN
        // Bad requests are consumed and counted but never reach the queue
        push_s    = acc_s && !enc_err_s;
        new_err_s = 1'b0;
`else
        push_s    = acc_s;
        new_err_s = enc_err_s;
`endif
        new_addr_s = addr_clr ? BASE_ADDR : addr_r;

        if (push_s) begin
            addr_nxt_s = new_addr_s + ADDR_STEP;
        end else if (addr_clr) begin
            addr_nxt_s = BASE_ADDR;
        end else begin
            addr_nxt_s = addr_r;
        end

        if (acc_s && enc_err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_nxt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end

        case ({push_s, pop_s})
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_instr_nxt_s = enc_instr_s;
                    head_addr_nxt_s  = new_addr_s;
                    head_err_nxt_s   = new_err_s;
                end else begin
                    tail_instr_nxt_s = enc_instr_s;
                    tail_addr_nxt_s  = new_addr_s;
                    tail_err_nxt_s   = new_err_s;
                end
                count_nxt_s = count_r + 2'd1;
            end
            2'b01: begin
                if (count_r == QUEUE_DEPTH) begin
                    head_instr_nxt_s = tail_instr_r;
                    head_addr_nxt_s  = tail_addr_r;
                    head_err_nxt_s   = tail_err_r;
                end else begin
                    head_instr_nxt_s = head_instr_r;
                    head_addr_nxt_s  = head_addr_r;
                    head_err_nxt_s   = head_err_r;
                end
                count_nxt_s = count_r - 2'd1;
            end
            2'b11: begin
                // Count is 1 here: the departing head is replaced directly
                if (count_r == 2'd1) begin
                    head_instr_nxt_s = enc_instr_s;
                    head_addr_nxt_s  = new_addr_s;
                    head_err_nxt_s   = new_err_s;
                end else begin
                    head_instr_nxt_s = tail_instr_r;
                    head_addr_nxt_s  = tail_addr_r;
                    head_err_nxt_s   = tail_err_r;
                    tail_instr_nxt_s = enc_instr_s;
                    tail_addr_nxt_s  = new_addr_s;
                    tail_err_nxt_s   = new_err_s;
                end
                count_nxt_s = count_r;
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_instr_r <= 32'h0000_0000;
            head_addr_r  <= BASE_ADDR;
            head_err_r   <= 1'b0;
            tail_instr_r <= 32'h0000_0000;
            tail_addr_r  <= BASE_ADDR;
            tail_err_r   <= 1'b0;
            count_r      <= 2'd0;
            addr_r       <= BASE_ADDR;
            err_cnt_r    <= 8'd0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
        end else begin
            head_instr_r <= head_instr_nxt_s;
            head_addr_r  <= head_addr_nxt_s;
            head_err_r   <= head_err_nxt_s;
            tail_instr_r <= tail_instr_nxt_s;
            tail_addr_r  <= tail_addr_nxt_s;
            tail_err_r   <= tail_err_nxt_s;
            count_r      <= count_nxt_s;
            addr_r       <= addr_nxt_s;
            err_cnt_r    <= err_cnt_nxt_s;
            in_ready_r   <= (count_nxt_s < QUEUE_DEPTH);
            out_valid_r  <= (count_nxt_s != 2'd0);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_instr = head_instr_r;
    assign out_addr  = head_addr_r;
    assign out_err   = head_err_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_imm_pack_writer.sv
// Randomized self-checking bench for imm_pack_writer against a queue-based reference
// model; honours IMM_PACK_ERR_DROP_EN the same way the design does.
module tb_imm_pack_writer;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_1000;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic        addr_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    imm_pack_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .addr_clr  (addr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_addr;
    int          m_errcnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] f, input logic [31:0] imm);
        int v;
        v = signed'(imm);
        case (f)
            2'd0:    return (v < -2048) || (v > 2047) || (v >= 1024 && v <= 1055);
            2'd1:    return (v < -2048) || (v > 2047);
            2'd2:    return (v < -4096) || (v > 4094) || (v % 2 != 0);
            default: return (v < 0) || (v > 31);
        endcase
    endfunction

    function automatic logic [31:0] put(input logic [31:0] w, input int lo, input int width,
                                        input logic [31:0] val);
        logic [31:0] mask;
        mask = ((32'd1 << width) - 32'd1) << lo;
        return (w & ~mask) | ((val << lo) & mask);
    endfunction

    function automatic logic [31:0] ref_pack(input logic [1:0] f, input logic [31:0] b,
                                             input logic [31:0] imm);
        logic [31:0] w;
        w = b;
        case (f)
            2'd0: w = put(w, 20, 12, imm);
            2'd1: begin
                w = put(w, 25, 7, imm >> 5);
                w = put(w, 7, 5, imm);
            end
            2'd2: begin
                w = put(w, 31, 1, imm >> 12);
                w = put(w, 7, 1, imm >> 11);
                w = put(w, 25, 6, imm >> 5);
                w = put(w, 8, 4, imm >> 1);
            end
            default: w = put(w, 20, 5, imm);
        endcase
        return w;
    endfunction

    // Wait to the falling edge and compare every output with the model
    task automatic sync();
        @(negedge clk);
        check_eq("in_ready", in_ready, q.size() < 2);
        check_eq("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("out_instr", out_instr, q[0].instr);
            check_eq("out_addr", out_addr, q[0].addr);
            check_eq("out_err", out_err, q[0].err);
        end
        check_eq("err_cnt", err_cnt, m_errcnt);
    endtask

    // Apply inputs for the next rising edge and advance the model accordingly
    task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] b,
                         input logic [31:0] im, input logic ordy, input logic clr);
        logic acc, pop, e, push;
        logic [31:0] a;
        in_valid  = v;
        in_fmt    = f;
        in_base   = b;
        in_imm    = im;
        out_ready = ordy;
        addr_clr  = clr;
        acc  = v && (q.size() < 2);
        pop  = (q.size() != 0) && ordy;
        e    = ref_err(f, im);
`ifdef IMM_PACK_ERR_DROP_EN
        push = acc && !e;
`else
        push = acc;
`endif
        if (pop) void'(q.pop_front());
        if (push) begin
            a = clr ? BASE : m_addr;
`ifdef IMM_PACK_ERR_DROP_EN
            q.push_back('{ref_pack(f, b, im), a, 1'b0});
`else
            q.push_back('{ref_pack(f, b, im), a, e});
`endif
            m_addr = a + 32'd4;
        end else if (clr) begin
            m_addr = BASE;
        end
        if (acc && e && m_errcnt < 255) m_errcnt++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        q.delete();
        m_addr   = BASE;
        m_errcnt = 0;
        sync();
        check_eq("rst_instr", out_instr, 32'h0000_0000);
        check_eq("rst_addr", out_addr, BASE);
        check_eq("rst_err", out_err, 1'b0);
        reset_n = 1'b1;
    endtask

    int bnd[12] = '{-2049, -2048, 2047, 2048, 1023, 1024, 1055, 1056, -4097, -4096, 4094, 4095};

    initial begin
        logic [31:0] im;
        logic [1:0]  f;
        reset_n = 1'b0;
        do_reset();

        // I pack
        drive(1'b1, 2'd0, 32'h0000_0013, 32'hFFFF_FFFF, 1'b1, 1'b0);
        sync();
        check_eq("i_pack", out_instr, 32'hFFF0_0013);
        check_eq("i_addr", out_addr, BASE);
        // B pack and misaligned B
        drive(1'b1, 2'd2, 32'h0000_0063, 32'hFFFF_FFFC, 1'b1, 1'b0);
        sync();
        check_eq("b_pack", out_instr, 32'hFE00_0EE3);
        drive(1'b1, 2'd2, 32'h0000_0063, 32'd3, 1'b1, 1'b0);
        sync();
        check_eq("b_odd_cnt", err_cnt, 8'd1);
`ifndef IMM_PACK_ERR_DROP_EN
        check_eq("b_odd_err", out_err, 1'b1);
`endif
        // Shift alias and SHAMT range
        drive(1'b1, 2'd0, 32'h0000_0013, 32'd1030, 1'b1, 1'b0);
        sync();
        check_eq("alias_cnt", err_cnt, 8'd2);
        drive(1'b1, 2'd3, 32'h4000_5013, 32'd7, 1'b1, 1'b0);
        sync();
        check_eq("shamt_pack", out_instr, 32'h4070_5013);
        check_eq("shamt_err", out_err, 1'b0);
        drive(1'b1, 2'd3, 32'h4000_5013, 32'd32, 1'b1, 1'b0);
        sync();
        check_eq("shamt_cnt", err_cnt, 8'd3);
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        sync();

        // Backpressure: three requests against a stalled sink
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 32'h0000_0013, 32'(i + 1), 1'b0, 1'b0);
            sync();
        end
        check_eq("bp_ready", in_ready, 1'b0);
        check_eq("bp_head", out_addr, BASE);
        drive(1'b1, 2'd0, 32'h0000_0013, 32'd3, 1'b1, 1'b0);
        sync();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
            sync();
        end

        // addr_clr coinciding with a push after five words
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd1, 32'h0000_0023, 32'(i), 1'b1, 1'b0);
            sync();
        end
        drive(1'b1, 2'd1, 32'h0000_0023, 32'd9, 1'b1, 1'b1);
        sync();
        check_eq("clr_addr", out_addr, BASE);
        drive(1'b1, 2'd1, 32'h0000_0023, 32'd10, 1'b1, 1'b0);
        sync();
        check_eq("clr_next", out_addr, BASE + 32'd4);

        // Reset with two entries queued
        drive(1'b1, 2'd0, 32'h0000_0013, 32'd5000, 1'b0, 1'b0);
        sync();
        drive(1'b1, 2'd0, 32'h0000_0013, 32'd6, 1'b0, 1'b0);
        sync();
        do_reset();
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_ready", in_ready, 1'b1);
        check_eq("mid_rst_cnt", err_cnt, 8'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                f = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       im = $urandom;
                    1:       im = 32'($urandom_range(0, 10000)) - 32'd5000;
                    2:       im = 32'(bnd[$urandom_range(0, 11)]);
                    default: im = 32'($urandom_range(0, 40));
                endcase
                drive($urandom_range(0, 3) != 0, f, $urandom, im,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
                sync();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
